// File: rtl/cpu_top.sv
// Single-cycle RV32I-subset core: PC, instruction ROM, register file, ALU, branch unit, data RAM.
// Optional macro CPU_ILLEGAL_HALT_EN: unsupported opcodes freeze the PC instead of acting as a NOP.

module cpu_dmem #(
  parameter int DMEM_BYTES = 1024,
  localparam int AW = $clog2(DMEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:2] word_addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [7:0] mem [0:DMEM_BYTES-1];
  logic [AW-1:0] a0, a1, a2, a3;

  assign a0 = {word_addr, 2'b00};
  assign a1 = {word_addr, 2'b01};
  assign a2 = {word_addr, 2'b10};
  assign a3 = {word_addr, 2'b11};

  assign rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[a0] <= wdata[7:0];
      mem[a1] <= wdata[15:8];
      mem[a2] <= wdata[23:16];
      mem[a3] <= wdata[31:24];
    end
  end
endmodule

module cpu_top #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256,
  parameter int          DMEM_BYTES = 1024,
  parameter string       IMEM_FILE  = "program.hex"
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] dbg_pc,
  output logic [31:0] dbg_instr
);
  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_BYTES);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  logic [31:0] pc_q, pc_d;
  logic [31:0] rf_q [0:31];
  logic [31:0] rf_d [0:31];
  logic [31:0] imem [0:IMEM_WORDS-1];

  // Unwritten ROM words read as NOP (addi x0,x0,0).
  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = 32'h0000_0013;
  end

  logic [31:0] instr;
  assign instr     = imem[pc_q[IW+1:2]];
  assign dbg_pc    = pc_q;
  assign dbg_instr = instr;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];
  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign f7  = instr[31:25];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  logic [31:0] rs1_v, rs2_v;
  assign rs1_v = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
  assign rs2_v = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];

  function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      3'b000:  r = alt ? a - b : a + b;
      3'b001:  r = a << b[4:0];
      3'b010:  r = {31'd0, $signed(a) < $signed(b)};
      3'b100:  r = a ^ b;
      3'b101:  r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  r = a | b;
      3'b111:  r = a & b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [31:0] pc4, mem_addr, ld_data;
  logic        mem_we, rf_we, illegal, lt, eq;
  logic [31:0] wb;

  assign pc4      = pc_q + 32'd4;
  assign mem_addr = rs1_v + ((opc == OP_ST) ? imm_s : imm_i);
  assign lt       = $signed(rs1_v) < $signed(rs2_v);
  assign eq       = rs1_v == rs2_v;

  // Store is gated by reset so an edge arriving while rst is low cannot write.
  cpu_dmem #(.DMEM_BYTES(DMEM_BYTES)) dmem_i (
    .clk      (clk),
    .we       (mem_we & rst),
    .word_addr(mem_addr[DW-1:2]),
    .wdata    (rs2_v),
    .rdata    (ld_data)
  );

  always_comb begin
    illegal = 1'b0;
    rf_we   = 1'b0;
    mem_we  = 1'b0;
    wb      = 32'd0;
    pc_d    = pc4;
    case (opc)
      OP_LUI:   begin rf_we = 1'b1; wb = imm_u; end
      OP_AUIPC: begin rf_we = 1'b1; wb = pc_q + imm_u; end
      OP_JAL:   begin rf_we = 1'b1; wb = pc4; pc_d = pc_q + imm_j; end
      OP_JALR: begin
        if (f3 != 3'b000) illegal = 1'b1;
        else begin
          rf_we = 1'b1;
          wb    = pc4;
          pc_d  = (rs1_v + imm_i) & ~32'd1;
        end
      end
      OP_BR: begin
        case (f3)
          3'b000:  if (eq)  pc_d = pc_q + imm_b;
          3'b001:  if (!eq) pc_d = pc_q + imm_b;
          3'b100:  if (lt)  pc_d = pc_q + imm_b;
          3'b101:  if (!lt) pc_d = pc_q + imm_b;
          default: illegal = 1'b1;
        endcase
      end
      OP_LD: begin
        if (f3 != 3'b010) illegal = 1'b1;
        else begin rf_we = 1'b1; wb = ld_data; end
      end
      OP_ST: begin
        if (f3 != 3'b010) illegal = 1'b1;
        else mem_we = 1'b1;
      end
      OP_IMM: begin
        // funct7 only matters for shifts; SLTIU is not part of the subset.
        if (f3 == 3'b011 || (f3 == 3'b001 && f7 != 7'h00) ||
            (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20))
          illegal = 1'b1;
        else begin
          rf_we = 1'b1;
          wb    = alu(f3, (f3 == 3'b101) & f7[5], rs1_v, imm_i);
        end
      end
      OP_REG: begin
        if (f3 == 3'b011 || !(f7 == 7'h00 ||
            (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101))))
          illegal = 1'b1;
        else begin
          rf_we = 1'b1;
          wb    = alu(f3, f7[5], rs1_v, rs2_v);
        end
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      rf_we  = 1'b0;
      mem_we = 1'b0;
`ifdef CPU_ILLEGAL_HALT_EN
      pc_d   = pc_q;
`else
      pc_d   = pc4;
`endif
    end
  end

  always_comb begin
    rf_d = rf_q;
    if (rf_we && rd != 5'd0) rf_d[rd] = wb;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      rf_q <= rf_d;
    end
  end
endmodule

// File: tb/tb_cpu_top.sv
// Directed program bench for cpu_top: PC trace, memory results, x0, halt/NOP and async reset.
module tb_cpu_top;
  logic        clk, rst;
  logic [31:0] dbg_pc, dbg_instr;
  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] rom [0:255];
  logic [31:0] exp_pc [$];

  cpu_top #(.RESET_PC(32'h0), .IMEM_WORDS(256), .DMEM_BYTES(1024), .IMEM_FILE("")) dut (
    .clk(clk), .rst(rst), .dbg_pc(dbg_pc), .dbg_instr(dbg_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] peek(input int a);
    return {dut.dmem_i.mem[a+3], dut.dmem_i.mem[a+2], dut.dmem_i.mem[a+1], dut.dmem_i.mem[a]};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0013;
    rom[0]  = enc_i(32'h55, 0, 3'b000, 1, 7'h13);        // addi x1,x0,0x55
    rom[1]  = enc_i(32'h4, 0, 3'b000, 2, 7'h13);         // addi x2,x0,4
    rom[2]  = enc_s(32'h0, 1, 2);                        // sw x1,0(x2)
    rom[3]  = enc_b(32'h8, 0, 0, 3'b000);                // beq x0,x0,+8
    rom[4]  = enc_i(32'h66, 0, 3'b000, 1, 7'h13);        // skipped
    rom[5]  = enc_i(32'h4, 0, 3'b010, 3, 7'h03);         // lw x3,4(x0)
    rom[6]  = enc_i(32'h1, 0, 3'b000, 0, 7'h13);         // addi x0,x0,1
    rom[7]  = enc_i(32'h2, 0, 3'b000, 4, 7'h13);         // addi x4,x0,2
    rom[8]  = enc_s(32'h8, 3, 0);                        // sw x3,8
    rom[9]  = enc_s(32'hC, 4, 0);                        // sw x4,12
    rom[10] = enc_j(32'hC, 5);                           // jal x5,+12
    rom[11] = enc_s(32'h10, 5, 0);                       // sw x5,16
    rom[12] = enc_j(32'hC, 0);                           // jal x0,+12
    rom[13] = enc_i(32'hFFFF_FFFF, 0, 3'b000, 6, 7'h13); // addi x6,x0,-1
    rom[14] = enc_i(32'h0, 5, 3'b000, 0, 7'h67);         // jalr x0,0(x5)
    rom[15] = {20'h80000, 5'd7, 7'h37};                  // lui x7,0x80000
    rom[16] = enc_i(32'h404, 7, 3'b101, 8, 7'h13);       // srai x8,x7,4
    rom[17] = enc_i(32'h004, 7, 3'b101, 9, 7'h13);       // srli x9,x7,4
    rom[18] = enc_r(7'h00, 0, 7, 3'b010, 10);            // slt x10,x7,x0
    rom[19] = enc_r(7'h20, 6, 1, 3'b000, 11);            // sub x11,x1,x6
    rom[20] = enc_i(32'hF0, 6, 3'b100, 12, 7'h13);       // xori x12,x6,0xf0
    rom[21] = {20'h00001, 5'd13, 7'h17};                 // auipc x13,1
    rom[22] = enc_b(32'h8, 0, 10, 3'b001);               // bne x10,x0,+8
    rom[23] = enc_i(32'h0, 0, 3'b000, 11, 7'h13);        // skipped
    rom[24] = enc_b(32'h8, 0, 6, 3'b100);                // blt x6,x0,+8
    rom[25] = enc_i(32'h0, 0, 3'b000, 11, 7'h13);        // skipped
    rom[26] = enc_b(32'h8, 0, 6, 3'b101);                // bge x6,x0 not taken
    rom[27] = enc_s(32'd20, 8, 0);
    rom[28] = enc_s(32'd24, 9, 0);
    rom[29] = enc_s(32'd28, 10, 0);
    rom[30] = enc_s(32'd32, 11, 0);
    rom[31] = enc_s(32'd36, 12, 0);
    rom[32] = enc_s(32'd40, 13, 0);
    rom[33] = enc_r(7'h00, 2, 10, 3'b001, 14);           // sll x14,x10,x2
    rom[34] = enc_i(32'h100, 14, 3'b110, 14, 7'h13);     // ori x14,x14,0x100
    rom[35] = enc_s(32'd44, 14, 0);
    rom[36] = enc_i(32'd7, 0, 3'b010, 15, 7'h03);        // lw x15,7(x0) -> word 4
    rom[37] = enc_s(32'd49, 15, 0);                      // sw x15,49 -> word 48
    rom[38] = 32'h0000_0000;                             // unsupported opcode

    exp_pc = '{0, 4, 8, 12, 20, 24, 28, 32, 36, 40, 52, 56, 44, 48, 60, 64, 68, 72,
               76, 80, 84, 88, 96, 104, 108, 112, 116, 120, 124, 128, 132, 136, 140,
               144, 148, 152};
`ifdef CPU_ILLEGAL_HALT_EN
    for (int i = 0; i < 5; i++) exp_pc.push_back(152);
`else
    exp_pc.push_back(156);
    exp_pc.push_back(160);
`endif

    rst = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.imem[i] = rom[i];
    #11;
    check("reset_pc", dbg_pc, 32'h0);
    check("reset_instr", dbg_instr, rom[0]);
    check("reset_x5", dut.rf_q[5], 32'h0);
    #5 rst = 1'b1;

    @(negedge clk);
    foreach (exp_pc[k]) begin
      check($sformatf("pc[%0d]", k), dbg_pc, exp_pc[k]);
      check($sformatf("instr[%0d]", k), dbg_instr, rom[dbg_pc[9:2]]);
      @(negedge clk);
    end

    check("mem4_sw",       peek(4),  32'h0000_0055);
    check("mem8_lw",       peek(8),  32'h0000_0055);
    check("mem12_x0",      peek(12), 32'h0000_0002);
    check("mem16_jal_link", peek(16), 32'd44);
    check("mem20_srai",    peek(20), 32'hF800_0000);
    check("mem24_srli",    peek(24), 32'h0800_0000);
    check("mem28_slt",     peek(28), 32'h0000_0001);
    check("mem32_sub",     peek(32), 32'h0000_0056);
    check("mem36_xori",    peek(36), 32'hFFFF_FF0F);
    check("mem40_auipc",   peek(40), 32'h0000_1054);
    check("mem44_sll_ori", peek(44), 32'h0000_0110);
    check("mem48_misalign", peek(48), 32'h0000_0055);

    // Asynchronous reset mid-program, away from any clock edge.
    #2 rst = 1'b0;
    #1;
    check("midrst_pc", dbg_pc, 32'h0);
    check("midrst_instr", dbg_instr, rom[0]);
    check("midrst_x5", dut.rf_q[5], 32'h0);
    check("midrst_x14", dut.rf_q[14], 32'h0);
    @(negedge clk);
    check("midrst_hold_pc", dbg_pc, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rerun_pc1", dbg_pc, 32'h4);
    check("rerun_x1", dut.rf_q[1], 32'h55);
    @(negedge clk);
    check("rerun_pc2", dbg_pc, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
